mon_pkt_dispatcher: RTL
=======================

MON_PKT_DISPATCHER -- requirements
Module: mon_pkt_dispatcher

Interface
REQ-001 SHALL have parameters C_AXIS_DATA_WIDTH=256 (stream data width), C_AXIS_TUSER_WIDTH=128 (tuser width), NUM_QUEUES=8 (destination bitmap width), DST_PORT_POS=24 (LSB of dst bitmap in tuser), PKT_FIFO_DEPTH_BITS=4 (packet FIFO depth log2), HIT_FIFO_DEPTH_BITS=3 (result FIFO depth log2), SNAP_WIDTH=8 (snap length width, words), CNT_WIDTH=32 (statistics counter width).
REQ-002 SHALL have one clock; reset is asynchronous and active-low, on ports: axi_aclk in 1 (clock); axi_resetn in 1 (reset).
REQ-003 SHALL have ports s_axis_tdata/tstrb/tuser/tvalid/tlast in (C_AXIS_DATA_WIDTH / C_AXIS_DATA_WIDTH/8 / C_AXIS_TUSER_WIDTH / 1 / 1), the ingress packet stream, and s_axis_tready out 1.
REQ-004 SHALL have ports m_axis_tdata/tstrb/tuser/tvalid/tlast out (same widths), the egress stream, and m_axis_tready in 1.
REQ-005 SHALL have lookup_dst_ports in NUM_QUEUES (per-packet lookup result) and lookup_done in 1 (result-valid strobe, one per packet, in packet order).
REQ-006 SHALL have config inputs drop_on_miss 1, snap_en 1, snap_words SNAP_WIDTH, and cnt_clear 1.
REQ-007 SHALL have status outputs pass_cnt, drop_cnt, trunc_cnt (CNT_WIDTH each) and hit_ovf 1 (sticky result-FIFO overflow).

Function
REQ-008 SHALL drive s_axis_tready = NOT packet-FIFO nearly_full, and write the FIFO on s_axis_tvalid AND s_axis_tready.
REQ-009 SHALL push lookup_dst_ports into the result FIFO on lookup_done; on lookup_done with the FIFO full, it SHALL discard the result and set hit_ovf.
REQ-010 SHALL implement states IDLE, SEND, DROP and FLUSH.
REQ-011 In IDLE with both FIFOs non-empty, the block SHALL latch drop_on_miss, snap_en and snap_words for the whole packet.
REQ-012 In IDLE, a miss (result==0) with drop_on_miss=1 SHALL pop the result, increment drop_cnt and enter DROP without asserting m_axis_tvalid.
REQ-013 Otherwise in IDLE, the block SHALL assert m_axis_tvalid with head word and tuser[DST_PORT_POS+NUM_QUEUES-1:DST_PORT_POS] = result; other tuser bits pass unchanged.
REQ-014 On that IDLE handshake, the block SHALL pop both FIFOs and set word count to 1, then go to IDLE if tlast (pass_cnt+1), else to SEND.
REQ-015 In SEND with the packet FIFO non-empty, the block SHALL present the head word unmodified and pop on handshake.
REQ-016 In SEND on handshake: tlast goes to IDLE (pass_cnt+1); otherwise word count increments.
REQ-017 When the latched snap_en=1, snap_words!=0 and the presented word is word number snap_words without tlast, the block SHALL force m_axis_tlast=1 and, on handshake, increment trunc_cnt and pass_cnt and enter FLUSH.
REQ-018 The rule of REQ-017 SHALL also apply to the first word in IDLE when snap_words=1.
REQ-019 snap_words=0 SHALL disable truncation; a packet ending exactly at snap_words words SHALL NOT count as truncated.
REQ-020 DROP and FLUSH SHALL pop one packet-FIFO word per cycle when non-empty, with m_axis_tvalid=0, and return to IDLE after popping the tlast word.
REQ-021 m_axis_tvalid SHALL NOT depend combinationally on m_axis_tready; outputs SHALL hold stable while tvalid AND NOT tready.
REQ-022 The first word SHALL appear on m_axis in the same cycle both FIFO heads are valid (zero added latency).
REQ-023 Counters SHALL saturate at all-ones.
REQ-024 cnt_clear SHALL synchronously zero all counters and hit_ovf, with clear winning over a simultaneous increment or overflow.

Reset
REQ-025 Asserting axi_resetn low SHALL immediately force state to IDLE, empty both FIFOs, zero counters and hit_ovf, and drive m_axis_tvalid=0.
REQ-026 A reset mid-packet SHALL discard the partial packet; egress SHALL resume at the next packet start.
REQ-027 s_axis_tready SHALL be 1 from the first clock edge after reset release.

Structure
REQ-028 State encoding and default parameter values SHALL live in the shared osnt monitoring package.
REQ-029 Both FIFOs SHALL be instances of one parametrised first-word-fall-through sub-module, mon_fwft_fifo (width, depth, nearly_full, empty).

Verification
REQ-030 Hit pass-through: 3-word packet with result 8'h05 and m_axis_tready=1 SHALL emit 3 words with tuser[31:24]=8'h05 on the first word only, pass_cnt=1.
REQ-031 Miss drop: result 0 with drop_on_miss=1 SHALL produce no m_axis_tvalid and drop_cnt=1; the next hit packet SHALL emit normally.
REQ-032 Truncation: 6-word packet with snap_en=1, snap_words=2 SHALL emit 2 words, the second with tlast=1, and give trunc_cnt=1; the next packet SHALL be unaffected.
REQ-033 Backpressure: m_axis_tready toggling 1/0 every cycle on a 4-word packet SHALL keep data stable while stalled, with no loss or duplication.
REQ-034 Overflow: 9 lookup_done pulses with no packets (HIT_FIFO_DEPTH_BITS=3) SHALL set hit_ovf=1, and cnt_clear SHALL return it to 0.
REQ-035 Reset mid-packet: axi_resetn low during word 2 of 4 SHALL drop m_axis_tvalid that cycle, and a fresh packet after release SHALL emit correctly.

Source files
------------

// File: rtl/mon_pkt_dispatcher_pkg.sv
// Shared monitoring definitions for the packet dispatcher: default parameter
// values and the dispatcher state encoding.
package mon_pkt_dispatcher_pkg;

   localparam int DEF_AXIS_DATA_WIDTH   = 256;
   localparam int DEF_AXIS_TUSER_WIDTH  = 128;
   localparam int DEF_NUM_QUEUES        = 8;
   localparam int DEF_DST_PORT_POS      = 24;
   localparam int DEF_PKT_FIFO_DEPTH_BITS = 4;
   localparam int DEF_HIT_FIFO_DEPTH_BITS = 3;
   localparam int DEF_SNAP_WIDTH        = 8;
   localparam int DEF_CNT_WIDTH         = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_DROP  = 2'd2,
      ST_FLUSH = 2'd3
   } disp_state_e;

endpackage

// File: rtl/mon_fwft_fifo.sv
// First-word-fall-through FIFO: dout shows the head entry whenever empty=0,
// and rd_en consumes it. Writes when full and reads when empty are ignored.
module mon_fwft_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_BITS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic             nearly_full
);

   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS + 1)'(DEPTH);
   localparam logic [DEPTH_BITS:0] NF_CNT   = (DEPTH_BITS + 1)'(DEPTH - 1);

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_BITS:0]   count_q, count_d;
   logic                  do_wr, do_rd;

   assign empty       = (count_q == '0);
   assign full        = (count_q == FULL_CNT);
   assign nearly_full = (count_q >= NF_CNT);
   assign do_wr       = wr_en && !full;
   assign do_rd       = rd_en && !empty;
   assign dout        = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/mon_pkt_dispatcher.sv
// Pairs each buffered packet with its in-order lookup result, stamps the
// destination bitmap into tuser, and passes, drops or truncates the packet.
module mon_pkt_dispatcher
   import mon_pkt_dispatcher_pkg::*;
#(
   parameter int C_AXIS_DATA_WIDTH   = DEF_AXIS_DATA_WIDTH,
   parameter int C_AXIS_TUSER_WIDTH  = DEF_AXIS_TUSER_WIDTH,
   parameter int NUM_QUEUES          = DEF_NUM_QUEUES,
   parameter int DST_PORT_POS        = DEF_DST_PORT_POS,
   parameter int PKT_FIFO_DEPTH_BITS = DEF_PKT_FIFO_DEPTH_BITS,
   parameter int HIT_FIFO_DEPTH_BITS = DEF_HIT_FIFO_DEPTH_BITS,
   parameter int SNAP_WIDTH          = DEF_SNAP_WIDTH,
   parameter int CNT_WIDTH           = DEF_CNT_WIDTH
) (
   input  logic                            axi_aclk,
   input  logic                            axi_resetn,
   input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                            s_axis_tvalid,
   input  logic                            s_axis_tlast,
   output logic                            s_axis_tready,
   output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
   output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                            m_axis_tvalid,
   output logic                            m_axis_tlast,
   input  logic                            m_axis_tready,
   input  logic [NUM_QUEUES-1:0]           lookup_dst_ports,
   input  logic                            lookup_done,
   input  logic                            drop_on_miss,
   input  logic                            snap_en,
   input  logic [SNAP_WIDTH-1:0]           snap_words,
   input  logic                            cnt_clear,
   output logic [CNT_WIDTH-1:0]            pass_cnt,
   output logic [CNT_WIDTH-1:0]            drop_cnt,
   output logic [CNT_WIDTH-1:0]            trunc_cnt,
   output logic                            hit_ovf,
   output logic [1:0]                      dbg_state
);

   localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
   localparam int PKT_W  = C_AXIS_DATA_WIDTH + STRB_W + C_AXIS_TUSER_WIDTH + 1;

   logic [PKT_W-1:0]              pkt_din, pkt_dout;
   logic                          pkt_wr, pkt_rd, pkt_empty, pkt_full, pkt_nearly_full;
   logic [NUM_QUEUES-1:0]         hit_dout;
   logic                          hit_rd, hit_empty, hit_full, hit_nearly_full;
   logic                          unused_ok;

   logic [C_AXIS_DATA_WIDTH-1:0]  head_data;
   logic [STRB_W-1:0]             head_strb;
   logic [C_AXIS_TUSER_WIDTH-1:0] head_user;
   logic                          head_last;

   disp_state_e                   state_q, state_d;
   logic [SNAP_WIDTH-1:0]         word_cnt_q, word_cnt_d;
   logic                          cfg_held_q, cfg_held_d;
   logic                          drop_cfg_q, drop_cfg_d;
   logic                          snap_en_cfg_q, snap_en_cfg_d;
   logic [SNAP_WIDTH-1:0]         snap_words_cfg_q, snap_words_cfg_d;
   logic [CNT_WIDTH-1:0]          pass_cnt_q, pass_cnt_d;
   logic [CNT_WIDTH-1:0]          drop_cnt_q, drop_cnt_d;
   logic [CNT_WIDTH-1:0]          trunc_cnt_q, trunc_cnt_d;
   logic                          hit_ovf_q, hit_ovf_d;

   logic                          both_ne, snap_hit;
   logic                          eff_drop, eff_snap_en;
   logic [SNAP_WIDTH-1:0]         eff_snap_words;
   logic [SNAP_WIDTH:0]           pres_num;
   logic                          pass_inc, drop_inc, trunc_inc;

   assign pkt_din       = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
   assign {head_last, head_user, head_strb, head_data} = pkt_dout;
   assign pkt_wr        = s_axis_tvalid && s_axis_tready;
   assign s_axis_tready = !(pkt_nearly_full || pkt_full);
   assign unused_ok     = hit_nearly_full;

   mon_fwft_fifo #(
      .WIDTH      (PKT_W),
      .DEPTH_BITS (PKT_FIFO_DEPTH_BITS)
   ) u_pkt_fifo (
      .clk         (axi_aclk),
      .rst_n       (axi_resetn),
      .wr_en       (pkt_wr),
      .din         (pkt_din),
      .rd_en       (pkt_rd),
      .dout        (pkt_dout),
      .empty       (pkt_empty),
      .full        (pkt_full),
      .nearly_full (pkt_nearly_full)
   );

   mon_fwft_fifo #(
      .WIDTH      (NUM_QUEUES),
      .DEPTH_BITS (HIT_FIFO_DEPTH_BITS)
   ) u_hit_fifo (
      .clk         (axi_aclk),
      .rst_n       (axi_resetn),
      .wr_en       (lookup_done),
      .din         (lookup_dst_ports),
      .rd_en       (hit_rd),
      .dout        (hit_dout),
      .empty       (hit_empty),
      .full        (hit_full),
      .nearly_full (hit_nearly_full)
   );

   // Config is sampled live on the first IDLE cycle of a packet and held in
   // the *_cfg registers from then on, so a stalled head word never changes.
   always_comb begin
      both_ne = !pkt_empty && !hit_empty;
      if (state_q == ST_IDLE && !cfg_held_q) begin
         eff_drop       = drop_on_miss;
         eff_snap_en    = snap_en;
         eff_snap_words = snap_words;
      end else begin
         eff_drop       = drop_cfg_q;
         eff_snap_en    = snap_en_cfg_q;
         eff_snap_words = snap_words_cfg_q;
      end
      pres_num = (state_q == ST_IDLE) ? (SNAP_WIDTH + 1)'(1)
                                      : {1'b0, word_cnt_q} + 1'b1;
      snap_hit = eff_snap_en && (eff_snap_words != '0) &&
                 ({1'b0, eff_snap_words} == pres_num) && !head_last;
   end

   // Egress handshake: a word transfers on a clock edge where m_axis_tvalid and
   // m_axis_tready are both high; tvalid is driven from FIFO/FSM state only,
   // and data/tuser/tlast hold while tvalid is high and tready is low.
   always_comb begin
      state_d          = state_q;
      word_cnt_d       = word_cnt_q;
      cfg_held_d       = cfg_held_q;
      drop_cfg_d       = drop_cfg_q;
      snap_en_cfg_d    = snap_en_cfg_q;
      snap_words_cfg_d = snap_words_cfg_q;
      pkt_rd           = 1'b0;
      hit_rd           = 1'b0;
      pass_inc         = 1'b0;
      drop_inc         = 1'b0;
      trunc_inc        = 1'b0;
      m_axis_tvalid    = 1'b0;
      m_axis_tdata     = head_data;
      m_axis_tstrb     = head_strb;
      m_axis_tuser     = head_user;
      m_axis_tlast     = head_last;
      case (state_q)
         ST_IDLE: begin
            if (both_ne) begin
               cfg_held_d       = 1'b1;
               drop_cfg_d       = eff_drop;
               snap_en_cfg_d    = eff_snap_en;
               snap_words_cfg_d = eff_snap_words;
               if (hit_dout == '0 && eff_drop) begin
                  hit_rd     = 1'b1;
                  drop_inc   = 1'b1;
                  cfg_held_d = 1'b0;
                  state_d    = ST_DROP;
               end else begin
                  m_axis_tvalid = 1'b1;
                  m_axis_tuser[DST_PORT_POS +: NUM_QUEUES] = hit_dout;
                  m_axis_tlast  = head_last || snap_hit;
                  if (m_axis_tready) begin
                     pkt_rd     = 1'b1;
                     hit_rd     = 1'b1;
                     cfg_held_d = 1'b0;
                     word_cnt_d = SNAP_WIDTH'(1);
                     if (snap_hit) begin
                        pass_inc  = 1'b1;
                        trunc_inc = 1'b1;
                        state_d   = ST_FLUSH;
                     end else if (head_last) begin
                        pass_inc = 1'b1;
                     end else begin
                        state_d = ST_SEND;
                     end
                  end
               end
            end
         end
         ST_SEND: begin
            if (!pkt_empty) begin
               m_axis_tvalid = 1'b1;
               m_axis_tlast  = head_last || snap_hit;
               if (m_axis_tready) begin
                  pkt_rd = 1'b1;
                  if (snap_hit) begin
                     pass_inc  = 1'b1;
                     trunc_inc = 1'b1;
                     state_d   = ST_FLUSH;
                  end else if (head_last) begin
                     pass_inc = 1'b1;
                     state_d  = ST_IDLE;
                  end else if (word_cnt_q != '1) begin
                     word_cnt_d = word_cnt_q + 1'b1;
                  end
               end
            end
         end
         ST_DROP, ST_FLUSH: begin
            if (!pkt_empty) begin
               pkt_rd = 1'b1;
               if (head_last) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Saturating statistics; a clear outranks any same-cycle event.
   always_comb begin
      pass_cnt_d  = pass_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      trunc_cnt_d = trunc_cnt_q;
      hit_ovf_d   = hit_ovf_q;
      if (cnt_clear) begin
         pass_cnt_d  = '0;
         drop_cnt_d  = '0;
         trunc_cnt_d = '0;
         hit_ovf_d   = 1'b0;
      end else begin
         if (pass_inc && pass_cnt_q != '1)   pass_cnt_d  = pass_cnt_q + 1'b1;
         if (drop_inc && drop_cnt_q != '1)   drop_cnt_d  = drop_cnt_q + 1'b1;
         if (trunc_inc && trunc_cnt_q != '1) trunc_cnt_d = trunc_cnt_q + 1'b1;
         if (lookup_done && hit_full)        hit_ovf_d   = 1'b1;
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q          <= ST_IDLE;
         word_cnt_q       <= '0;
         cfg_held_q       <= 1'b0;
         drop_cfg_q       <= 1'b0;
         snap_en_cfg_q    <= 1'b0;
         snap_words_cfg_q <= '0;
         pass_cnt_q       <= '0;
         drop_cnt_q       <= '0;
         trunc_cnt_q      <= '0;
         hit_ovf_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         word_cnt_q       <= word_cnt_d;
         cfg_held_q       <= cfg_held_d;
         drop_cfg_q       <= drop_cfg_d;
         snap_en_cfg_q    <= snap_en_cfg_d;
         snap_words_cfg_q <= snap_words_cfg_d;
         pass_cnt_q       <= pass_cnt_d;
         drop_cnt_q       <= drop_cnt_d;
         trunc_cnt_q      <= trunc_cnt_d;
         hit_ovf_q        <= hit_ovf_d;
      end
   end

   assign pass_cnt  = pass_cnt_q;
   assign drop_cnt  = drop_cnt_q;
   assign trunc_cnt = trunc_cnt_q;
   assign hit_ovf   = hit_ovf_q;
   assign dbg_state = state_q;

endmodule
